// File: rtl/usb_bit_unstuffer.sv
// rtl/usb_bit_unstuffer.sv - USB RX bit unstuffer: drops stuffed zeros, flags stuff errors
module usb_bit_unstuffer #(
    parameter int RUN_LEN = 6,
    parameter int CNT_W   = 3
) (
    input  logic clk,
    input  logic n_rst,
    input  logic rcving,
    input  logic shift_enable,
    input  logic d_orig,
    output logic data_out,
    output logic data_valid,
    output logic stuff_skip,
    output logic stuff_error,
    output logic err_sticky
);

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        STUFF  = 2'd1,
        ERROR  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic             data_out_q, data_out_d;
    logic             data_valid_q, data_valid_d;
    logic             stuff_skip_q, stuff_skip_d;
    logic             stuff_error_q, stuff_error_d;
    logic             err_sticky_q, err_sticky_d;

    always_comb begin
        state_d       = state_q;
        run_cnt_d     = run_cnt_q;
        data_out_d    = data_out_q;
        data_valid_d  = 1'b0;
        stuff_skip_d  = 1'b0;
        stuff_error_d = 1'b0;
        err_sticky_d  = err_sticky_q;

        // Leaving a packet wins over any strobe in the same cycle.
        if (!rcving) begin
            state_d      = NORMAL;
            run_cnt_d    = '0;
            err_sticky_d = 1'b0;
        end else if (shift_enable) begin
            case (state_q)
                NORMAL: begin
                    data_valid_d = 1'b1;
                    data_out_d   = d_orig;
                    if (!d_orig) begin
                        run_cnt_d = '0;
                    end else if (run_cnt_q == CNT_W'(RUN_LEN - 1)) begin
                        state_d   = STUFF;
                        run_cnt_d = '0;
                    end else begin
                        run_cnt_d = run_cnt_q + 1'b1;
                    end
                end
                STUFF: begin
                    if (!d_orig) begin
                        stuff_skip_d = 1'b1;
                        run_cnt_d    = '0;
                        state_d      = NORMAL;
                    end else begin
                        stuff_error_d = 1'b1;
                        err_sticky_d  = 1'b1;
                        state_d       = ERROR;
                    end
                end
                default: begin
                    err_sticky_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            state_q       <= NORMAL;
            run_cnt_q     <= '0;
            data_out_q    <= 1'b0;
            data_valid_q  <= 1'b0;
            stuff_skip_q  <= 1'b0;
            stuff_error_q <= 1'b0;
            err_sticky_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            run_cnt_q     <= run_cnt_d;
            data_out_q    <= data_out_d;
            data_valid_q  <= data_valid_d;
            stuff_skip_q  <= stuff_skip_d;
            stuff_error_q <= stuff_error_d;
            err_sticky_q  <= err_sticky_d;
        end
    end

    assign data_out    = data_out_q;
    assign data_valid  = data_valid_q;
    assign stuff_skip  = stuff_skip_q;
    assign stuff_error = stuff_error_q;
    assign err_sticky  = err_sticky_q;

endmodule

// File: tb/tb_usb_bit_unstuffer.sv
// tb/tb_usb_bit_unstuffer.sv - scoreboard bench for usb_bit_unstuffer
module tb_usb_bit_unstuffer;

    logic clk = 1'b0;
    logic n_rst;
    logic rcving;
    logic shift_enable;
    logic d_orig;
    logic data_out;
    logic data_valid;
    logic stuff_skip;
    logic stuff_error;
    logic err_sticky;

    typedef struct packed {
        logic v;
        logic d;
        logic s;
        logic e;
        logic st;
    } exp_t;

    exp_t exp_q[$];
    logic strobe_seen = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    usb_bit_unstuffer #(.RUN_LEN(6), .CNT_W(3)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .rcving       (rcving),
        .shift_enable (shift_enable),
        .d_orig       (d_orig),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .stuff_skip   (stuff_skip),
        .stuff_error  (stuff_error),
        .err_sticky   (err_sticky)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    always @(posedge clk) strobe_seen <= shift_enable;

    // Each sampled strobe must match the next queued expectation; idle cycles must be quiet.
    always @(negedge clk) begin
        if (strobe_seen) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_underflow", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_eq("data_valid", data_valid, e.v);
                if (e.v) check_eq("data_out", data_out, e.d);
                check_eq("stuff_skip", stuff_skip, e.s);
                check_eq("stuff_error", stuff_error, e.e);
                check_eq("err_sticky", err_sticky, e.st);
            end
        end else if (!n_rst) begin
            check_eq("idle_pulses", {data_valid, stuff_skip, stuff_error}, 3'b000);
        end
    end

    task automatic strobe(input logic d, input logic v, input logic s, input logic e, input logic st);
        @(posedge clk); #2;
        shift_enable = 1'b1;
        d_orig       = d;
        exp_q.push_back('{v: v, d: d, s: s, e: e, st: st});
        @(posedge clk); #2;
        shift_enable = 1'b0;
    endtask

    task automatic drop_rcving();
        @(posedge clk); #2;
        rcving = 1'b0;
        @(posedge clk); #2;
        rcving = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] pat;
        n_rst = 1'b1; rcving = 1'b0; shift_enable = 1'b0; d_orig = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check_eq("rst_outputs", {data_out, data_valid, stuff_skip, stuff_error, err_sticky}, 5'b0);
        n_rst = 1'b0;
        @(posedge clk); #2;
        rcving = 1'b1;

        // Plain data, no stuffing
        pat = 5'b01101;
        for (int i = 0; i < 5; i++) strobe(pat[i], 1'b1, 1'b0, 1'b0, 1'b0);
        drop_rcving();

        // Six ones then a stuffed zero, then more data
        for (int i = 0; i < 6; i++) strobe(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        strobe(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        strobe(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drop_rcving();

        // Stuff error and sticky behaviour
        for (int i = 0; i < 6; i++) strobe(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        strobe(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        strobe(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        strobe(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #2;
        rcving = 1'b0;
        @(posedge clk); #2;
        check_eq("sticky_cleared", err_sticky, 1'b0);
        rcving = 1'b1;

        // Counter restarts after each stuffed zero
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 6; i++) strobe(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            strobe(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        drop_rcving();

        // rcving drop coincident with a strobe clears the run and yields no pulse
        for (int i = 0; i < 5; i++) strobe(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #2;
        rcving = 1'b0; shift_enable = 1'b1; d_orig = 1'b1;
        exp_q.push_back('{v: 1'b0, d: 1'b1, s: 1'b0, e: 1'b0, st: 1'b0});
        @(posedge clk); #2;
        rcving = 1'b1; shift_enable = 1'b0;
        strobe(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        strobe(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drop_rcving();

        // Async reset while waiting for the stuffed bit
        for (int i = 0; i < 6; i++) strobe(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #2;
        n_rst = 1'b1;
        #1;
        check_eq("async_rst", {data_out, data_valid, stuff_skip, stuff_error, err_sticky}, 5'b0);
        @(posedge clk); #2;
        n_rst = 1'b0;
        strobe(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        check_eq("sb_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
